// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer with one outstanding bus request, held instruction and PC redirect
module fetch_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_INIT = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ir_addr_valid,
  input  logic                  ir_addr_ready,
  output logic [ADDR_WIDTH-1:0] ir_addr,
  input  logic                  ir_data_valid,
  output logic                  ir_data_ready,
  input  logic [INST_WIDTH-1:0] ir_data,
  output logic [INST_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc
);
  typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] pc, pc_n, addr_q;
  logic discard, discard_n, live, take;
  always_comb begin
    state_n = state;
    discard_n = discard;
    take = 1'b0;
    case (state)
      REQ: begin
        state_n = ir_addr_valid && ir_addr_ready ? WAIT : REQ;
        discard_n = discard || redirect_valid;
      end
      WAIT: begin
        take = ir_data_valid && !discard && !redirect_valid;
        state_n = !ir_data_valid ? WAIT : take ? HOLD : REQ;
        discard_n = ir_data_valid ? 1'b0 : discard || redirect_valid;
      end
      HOLD: state_n = inst_ready || redirect_valid ? REQ : HOLD;
      default: state_n = REQ;
    endcase
    pc_n = redirect_valid ? redirect_pc & ~ADDR_WIDTH'(3) : take ? pc + ADDR_WIDTH'(4) : pc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= REQ;
      pc <= PC_INIT;
      addr_q <= PC_INIT;
      discard <= 1'b0;
      live <= 1'b0;
      inst <= '0;
      inst_pc <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      discard <= discard_n;
      live <= 1'b1;
      if (state != REQ) addr_q <= pc_n;
      if (take) begin
        inst <= ir_data;
        inst_pc <= pc;
      end
    end
  end
  assign ir_addr_valid = live && state == REQ;
  assign ir_data_ready = state == WAIT;
  assign inst_valid = state == HOLD;
  assign ir_addr = addr_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench for fetch_ctrl with a latency-programmable instruction bus model
module tb_fetch_ctrl;
  logic clk, rst;
  logic ir_addr_valid, ir_addr_ready, ir_data_valid, ir_data_ready;
  logic [31:0] ir_addr, ir_data, inst, inst_pc, redirect_pc;
  logic inst_valid, inst_ready, redirect_valid;
  int checks = 0, errors = 0, data_delay = 0;
  logic [31:0] exp_a[$], exp_i[$], exp_p[$];
  fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .ir_addr_valid(ir_addr_valid), .ir_addr_ready(ir_addr_ready), .ir_addr(ir_addr),
    .ir_data_valid(ir_data_valid), .ir_data_ready(ir_data_ready), .ir_data(ir_data),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end
  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h00500093 ^ (a << 7);
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_hold(input string tag);
    int n = 0;
    while (!inst_valid && n < 20) begin
      tick;
      n++;
    end
    check(tag, inst_valid, 1);
  endtask
  task automatic push_inst(input logic [31:0] a);
    exp_i.push_back(word(a));
    exp_p.push_back(a);
  endtask
  initial begin
    logic r, a_hs, d_hs, pending;
    logic [31:0] a_addr, paddr;
    int dcnt;
    pending = 0;
    paddr = 0;
    dcnt = 0;
    ir_data_valid = 0;
    ir_data = 0;
    forever begin
      @(negedge clk);
      r = rst;
      a_hs = !r && ir_addr_valid && ir_addr_ready;
      d_hs = !r && ir_data_valid && ir_data_ready;
      a_addr = ir_addr;
      if (a_hs) begin
        if (exp_a.size() > 0) check("sb_addr", ir_addr, exp_a.pop_front());
        else check("sb_addr_extra", ir_addr, 'x);
      end
      if (!r && inst_valid && inst_ready) begin
        if (exp_i.size() > 0) begin
          check("sb_inst", inst, exp_i.pop_front());
          check("sb_inst_pc", inst_pc, exp_p.pop_front());
        end else check("sb_inst_extra", inst, 'x);
      end
      @(posedge clk);
      #1;
      if (r) pending = 0;
      else begin
        if (d_hs) pending = 0;
        if (a_hs) begin
          pending = 1;
          paddr = a_addr;
          dcnt = data_delay;
        end else if (pending && dcnt > 0) dcnt--;
      end
      ir_data_valid = pending && dcnt == 0;
      ir_data = word(paddr);
    end
  end
  initial begin
    int n;
    rst = 1;
    ir_addr_ready = 1;
    inst_ready = 1;
    redirect_valid = 0;
    redirect_pc = 0;
    tick;
    tick;
    check("rst_addr_valid", ir_addr_valid, 0);
    check("rst_data_ready", ir_data_ready, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_addr", ir_addr, 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    exp_a.push_back(0);
    exp_a.push_back(4);
    exp_a.push_back(8);
    exp_a.push_back(12);
    push_inst(0);
    push_inst(4);
    push_inst(8);
    rst = 0;
    tick;
    check("t1_req_valid", ir_addr_valid, 1);
    check("t1_req_addr", ir_addr, 0);
    tick;
    check("t1_wait_ready", ir_data_ready, 1);
    check("t1_wait_inst_valid", inst_valid, 0);
    tick;
    check("t1_hold_valid", inst_valid, 1);
    check("t1_inst", inst, 32'h00500093);
    check("t1_inst_pc", inst_pc, 0);
    tick;
    check("t1_next_valid", ir_addr_valid, 1);
    check("t1_next_addr", ir_addr, 4);
    inst_ready = 0;
    tick;
    tick;
    for (int i = 0; i < 4; i++) begin
      check("t3_hold_valid", inst_valid, 1);
      check("t3_hold_inst", inst, word(4));
      check("t3_hold_pc", inst_pc, 4);
      check("t3_no_req", ir_addr_valid, 0);
      if (i < 3) tick;
    end
    inst_ready = 1;
    ir_addr_ready = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      check("t2_stall_valid", ir_addr_valid, 1);
      check("t2_stall_addr", ir_addr, 8);
    end
    ir_addr_ready = 1;
    data_delay = 2;
    wait_hold("t2_hold_seen");
    check("t2_inst", inst, word(8));
    tick;
    check("t4_req_valid", ir_addr_valid, 1);
    check("t4_req_addr", ir_addr, 12);
    tick;
    check("t4_wait", ir_data_ready, 1);
    exp_a.push_back(32'h100);
    push_inst(32'h100);
    redirect_valid = 1;
    redirect_pc = 32'h103;
    tick;
    redirect_valid = 0;
    n = 0;
    while (!ir_addr_valid && n < 20) begin
      check("t4_dropped", inst_valid, 0);
      tick;
      n++;
    end
    check("t4_req_seen", ir_addr_valid, 1);
    check("t4_redirect_addr", ir_addr, 32'h100);
    wait_hold("t4_hold_seen");
    check("t4_inst_pc", inst_pc, 32'h100);
    ir_addr_ready = 0;
    tick;
    check("t5_req_addr", ir_addr, 32'h104);
    redirect_valid = 1;
    redirect_pc = 32'h200;
    tick;
    redirect_valid = 0;
    check("t5_held_valid", ir_addr_valid, 1);
    check("t5_held_addr", ir_addr, 32'h104);
    tick;
    check("t5_held_addr2", ir_addr, 32'h104);
    exp_a.push_back(32'h104);
    exp_a.push_back(32'h200);
    push_inst(32'h200);
    ir_addr_ready = 1;
    wait_hold("t5_hold_seen");
    check("t5_inst_pc", inst_pc, 32'h200);
    check("t5_inst", inst, word(32'h200));
    exp_a.push_back(32'hFFFF_FFFC);
    exp_a.push_back(0);
    exp_a.push_back(4);
    push_inst(32'hFFFF_FFFC);
    push_inst(0);
    redirect_valid = 1;
    redirect_pc = 32'hFFFF_FFFF;
    tick;
    redirect_valid = 0;
    check("t6_req_addr", ir_addr, 32'hFFFF_FFFC);
    wait_hold("t6_hold_top");
    check("t6_inst_pc_top", inst_pc, 32'hFFFF_FFFC);
    tick;
    check("t6_wrap_addr", ir_addr, 0);
    wait_hold("t6_hold_zero");
    check("t6_inst_pc_zero", inst_pc, 0);
    tick;
    check("t6_req4", ir_addr, 4);
    tick;
    check("t6_wait", ir_data_ready, 1);
    rst = 1;
    tick;
    check("t6_rst_addr_valid", ir_addr_valid, 0);
    check("t6_rst_data_ready", ir_data_ready, 0);
    check("t6_rst_inst_valid", inst_valid, 0);
    check("t6_rst_addr", ir_addr, 0);
    exp_a.push_back(0);
    push_inst(0);
    rst = 0;
    tick;
    check("t6_restart_valid", ir_addr_valid, 1);
    check("t6_restart_addr", ir_addr, 0);
    wait_hold("t6_restart_hold");
    ir_addr_ready = 0;
    check("t6_restart_inst", inst, 32'h00500093);
    tick;
    tick;
    check("sb_addr_left", exp_a.size(), 0);
    check("sb_inst_left", exp_i.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
